// File: rtl/keypad_pkg.sv
// Shared types, defaults and frame classifier for the 4x4 key matrix scanner.
package keypad_pkg;

  localparam int SCAN_DIV_W_DEF      = 12;
  localparam int DEBOUNCE_FRAMES_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_PRESS_WAIT = 2'd1,
    ST_HELD       = 2'd2,
    ST_REL_WAIT   = 2'd3
  } scan_state_e;

  typedef enum logic [1:0] {
    CLS_NONE   = 2'd0,
    CLS_SINGLE = 2'd1,
    CLS_MULTI  = 2'd2
  } frame_class_e;

  typedef struct packed {
    frame_class_e cls;
    logic [3:0]   code;
  } frame_info_t;

  // A snapshot bit is low when its key is pressed; bit index = col*4 + row.
  function automatic frame_info_t classify(input logic [15:0] snap);
    frame_info_t info;
    logic [4:0]  n;
    info.cls  = CLS_NONE;
    info.code = 4'd0;
    n         = 5'd0;
    for (int i = 0; i < 16; i++) begin
      if (!snap[i]) begin
        n         = n + 5'd1;
        info.code = 4'(i);
      end
    end
    if (n == 5'd1)     info.cls = CLS_SINGLE;
    else if (n > 5'd1) info.cls = CLS_MULTI;
    return info;
  endfunction

endpackage

// File: rtl/key_sync.sv
// Two-flop synchronizer for the asynchronous row returns; idles high like the pulled-up rows.
module key_sync #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/key_scan.sv
// 4x4 key matrix scanner: strobes columns, snapshots rows per frame, and
// debounces single-key presses and releases over whole frames.
module key_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV_W      = SCAN_DIV_W_DEF,
  parameter int DEBOUNCE_FRAMES = DEBOUNCE_FRAMES_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [3:0] col,
  input  logic [3:0] row,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held,
  output logic [1:0] dbg_state_o
);

  localparam logic [3:0] DEB_CNT = 4'(DEBOUNCE_FRAMES);

  logic [3:0]            row_sync;
  logic [SCAN_DIV_W-1:0] slot_q;
  logic [1:0]            col_idx_q;
  logic [15:0]           snap_q;
  logic [15:0]           snap_now;
  logic                  slot_end;
  logic                  frame_end;
  frame_info_t           info;

  scan_state_e state_q, state_d;
  logic [3:0]  cnt_q, cnt_d, cnt_inc;
  logic [3:0]  cand_q, cand_d;
  logic [3:0]  code_q, code_d;
  logic        valid_q, valid_d;

  key_sync #(.W(4)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (row),
    .q_o   (row_sync)
  );

  assign slot_end  = &slot_q;
  assign frame_end = slot_end && (col_idx_q == 2'd3);

  // Classification sees the column-3 sample being taken this cycle.
  always_comb begin
    snap_now = snap_q;
    snap_now[{col_idx_q, 2'b00} +: 4] = row_sync;
  end

  assign info    = classify(snap_now);
  assign cnt_inc = (cnt_q == 4'hF) ? 4'hF : cnt_q + 4'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_q    <= '0;
      col_idx_q <= 2'd0;
      snap_q    <= '1;
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      cand_q    <= 4'd0;
      code_q    <= 4'd0;
      valid_q   <= 1'b0;
    end else begin
      slot_q  <= slot_q + 1'b1;
      if (slot_end) begin
        col_idx_q <= col_idx_q + 2'd1;
        snap_q    <= snap_now;
      end
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
      code_q  <= code_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    code_d  = code_q;
    valid_d = 1'b0;
    if (frame_end) begin
      case (state_q)
        ST_IDLE: begin
          if (info.cls == CLS_SINGLE) begin
            state_d = ST_PRESS_WAIT;
            cand_d  = info.code;
            cnt_d   = 4'd1;
          end
        end
        ST_PRESS_WAIT: begin
          if (info.cls == CLS_SINGLE && info.code == cand_q) begin
            cnt_d = cnt_inc;
            if (cnt_inc >= DEB_CNT) begin
              state_d = ST_HELD;
              code_d  = cand_q;
              valid_d = 1'b1;
            end
          end else begin
            state_d = ST_IDLE;
            cnt_d   = 4'd0;
          end
        end
        ST_HELD: begin
          // Extra keys while held are ignored; only a clean NONE frame starts release.
          if (info.cls == CLS_NONE) begin
            state_d = ST_REL_WAIT;
            cnt_d   = 4'd1;
          end
        end
        ST_REL_WAIT: begin
          if (info.cls == CLS_NONE) begin
            cnt_d = cnt_inc;
            if (cnt_inc >= DEB_CNT) begin
              state_d = ST_IDLE;
              cnt_d   = 4'd0;
            end
          end else begin
            state_d = ST_HELD;
            cnt_d   = 4'd0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign col         = ~(4'b0001 << col_idx_q);
  assign key_code    = code_q;
  assign key_valid   = valid_q;
  assign key_held    = (state_q == ST_HELD) || (state_q == ST_REL_WAIT);
  assign dbg_state_o = state_q;

endmodule

// File: doc/key_scan.md
KEY_SCAN -- requirements
Module: key_scan

Interface
REQ-001 SHALL have parameter SCAN_DIV_W, default 12: column slot length is 2^SCAN_DIV_W clk cycles.
REQ-002 SHALL have parameter DEBOUNCE_FRAMES, default 4: number of consecutive identical frames needed to accept a press or release; legal range 2..15.
REQ-003 SHALL have port clk, input, 1, the single system clock.
REQ-004 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-005 SHALL have port col, output, 4, active-low one-hot column strobe to the 4x4 key matrix.
REQ-006 SHALL have port row, input, 4, active-low row returns from the matrix (externally pulled up), asynchronous to clk.
REQ-007 SHALL have port key_code, output, 4, code of the accepted key, equal to column index*4 + row index.
REQ-008 SHALL have port key_valid, output, 1, one-cycle pulse when a debounced press is accepted.
REQ-009 SHALL have port key_held, output, 1, high from acceptance until a debounced release.

Function
REQ-010 SHALL pass row through a 2-flop synchronizer before any use.
REQ-011 SHALL drive exactly one col bit low at all times, cycling 0,1,2,3,0,... and advancing when the slot counter wraps from all-ones to zero.
REQ-012 SHALL sample the synchronized rows on the last cycle of each slot, giving 2^SCAN_DIV_W-1 cycles of settling; the sample is stored into the 4 snapshot bits of the current column.
REQ-013 SHALL treat the sample taken in the column-3 slot as the end of a frame and classify the 16-bit snapshot as NONE (0 keys), SINGLE(k) (exactly 1 key, code k) or MULTI (2 or more keys).
REQ-014 SHALL implement states IDLE, PRESS_WAIT, HELD, REL_WAIT, evaluated once per frame end.
REQ-015 IDLE: SINGLE(k) -> PRESS_WAIT with cand=k, cnt=1; NONE or MULTI -> stay.
REQ-016 PRESS_WAIT: SINGLE(cand) -> cnt+1, and on reaching DEBOUNCE_FRAMES -> HELD; any other class -> IDLE with cnt=0.
REQ-017 On the PRESS_WAIT->HELD transition, SHALL load key_code=cand and assert key_valid for exactly one cycle, the cycle after the frame-end sample.
REQ-018 HELD: NONE -> REL_WAIT with cnt=1; SINGLE or MULTI -> stay (an extra key while held is ignored; key_code is unchanged).
REQ-019 REL_WAIT: NONE -> cnt+1, and on reaching DEBOUNCE_FRAMES -> IDLE; any other class -> HELD with cnt=0.
REQ-020 key_held SHALL be 1 in HELD and REL_WAIT, 0 otherwise; key_code SHALL hold its last accepted value until the next acceptance.
REQ-021 cnt SHALL be 4 bits, saturating, never wrapping.
REQ-022 The slot counter SHALL be SCAN_DIV_W bits and wrap freely; the column index SHALL be 2 bits and wrap from 3 to 0.

Reset
REQ-023 While rst_n=0 at a clk edge: col=4'b1110, slot counter=0, synchronizer and snapshot all ones (idle), state=IDLE, cnt=0, cand=0, key_code=0, key_valid=0, key_held=0.
REQ-024 Reset asserted mid-operation (any state, including the key_valid cycle) SHALL take effect on that edge and suppress any pending pulse; scanning restarts at column 0 on the first edge with rst_n=1.

Structure
REQ-025 State encodings, the NONE/SINGLE/MULTI class codes and the parameter defaults SHALL live in the shared package keypad_pkg.
REQ-026 The 2-flop row synchronizer SHALL be the sub-module key_sync, 4 bits wide; everything else is in key_scan.

Verification (SCAN_DIV_W=4: 16-cycle slot, 64-cycle frame; DEBOUNCE_FRAMES=3)
REQ-027 Reset then idle rows=4'hF -> col sequence 1110,1101,1011,0111, each held 16 cycles; key_valid never asserts; key_held=0.
REQ-028 Hold key col2/row1 for 5 frames -> exactly one key_valid pulse, key_code=4'd9, at the end of the 3rd full frame; key_held=1 until 3 NONE frames after release.
REQ-029 Bounce: key 9 present for 2 frames, absent for 1, present for 3 -> a single pulse at the end of the 3rd frame of the second contact, never earlier.
REQ-030 Keys 0 and 5 pressed together for 6 frames -> no key_valid and key_held=0; then release key 5 -> key_valid with key_code=0 after 3 frames.
REQ-031 While key 3 is held, add key 12 for 4 frames, then release both -> no second pulse, key_code stays 3; key_held drops after 3 NONE frames.
REQ-032 Assert rst_n=0 for 1 cycle during PRESS_WAIT (cnt=2) -> all outputs return to reset values, col=1110; with the key still pressed, the pulse arrives 3 full frames after reset release.
